// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings and the FSM state type for the single-master
// initiator (ahb_lite_single_master) and its timeout counter.
//   - HTRANS, HSIZE, HBURST and HRESP codes
//   - ahbm_state_e : initiator FSM states
//   - cmd_is_legal : size/alignment check for a local command
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Read data reported when a transfer is abandoned by the timeout.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } ahbm_state_e;

  // Only byte/half/word sizes exist on a 32-bit bus, and the address must be
  // naturally aligned to the size.
  function automatic logic cmd_is_legal(input logic [2:0] size,
                                        input logic [1:0] addr_lsb);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lsb[0];
      HSIZE_WORD: ok = (addr_lsb == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahbm_timeout_ctr.sv
// ---------------------------------------------------------------------------
// ahbm_timeout_ctr
// Counts consecutive HREADY-low cycles while a transfer is on the bus and
// flags expiry on the TIMEOUT_CYCLES-th such cycle. Only built when the
// initiator is compiled with AHBM_TIMEOUT_EN.
// Ports:
//   clk_i      : bus clock
//   rst_ni     : synchronous active-low reset
//   active_i   : initiator is in its address or data phase
//   hready_i   : bus HREADY
//   expired_o  : this cycle is the TIMEOUT_CYCLES-th consecutive low cycle
// ---------------------------------------------------------------------------
module ahbm_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic hready_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = active_i && !hready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Any HREADY-high cycle ends a phase (and thus changes state), as does
  // expiry, so all state changes clear the count here as well.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!active_i || hready_i || expired_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ahb_lite_single_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_single_master
// Non-pipelined AHB-Lite initiator: each command accepted on the local
// cmd_* port becomes one SINGLE transfer; the result is returned on rsp_*.
// Optional macro AHBM_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES
// consecutive HREADY-low cycles (rsp_err=1, rsp_rdata=32'hDEADBEEF).
//
// Handshakes: a transfer on cmd_* happens on a rising HCLK edge where
// cmd_valid && cmd_ready; a transfer on rsp_* happens on an edge where
// rsp_valid && rsp_ready. Once asserted, rsp_valid/rsp_rdata/rsp_err hold
// until that edge. cmd_ready is high only in IDLE.
//
// Ports:
//   HCLK, HRESETn          : clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/size/wdata : command port
//   rsp_valid/ready/rdata/err              : response port
//   HADDR..HWDATA (out), HRDATA/HREADY/HRESP (in) : AHB-Lite master side
//   dbg_state              : current FSM state
// ---------------------------------------------------------------------------
module ahb_lite_single_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL      = 4'b0011,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  output ahbm_state_e dbg_state
);

  ahbm_state_e state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cmd_legal;
  logic        tmo_expired;

  assign cmd_legal = cmd_is_legal(cmd_size, cmd_addr[1:0]);

`ifdef AHBM_TIMEOUT_EN
  logic tmo_active;
  assign tmo_active = (state_q == ST_ADDR) || (state_q == ST_DATA);

  ahbm_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .active_i  (tmo_active),
    .hready_i  (HREADY),
    .expired_o (tmo_expired)
  );
`else
  logic unused_tmo_cfg;
  assign tmo_expired    = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          haddr_d  = cmd_addr;
          hwrite_d = cmd_write;
          hsize_d  = cmd_size;
          if (cmd_write) begin
            hwdata_d = cmd_wdata;
          end
          if (cmd_legal) begin
            state_d = ST_ADDR;
          end else begin
            // Rejected locally; the bus never sees this command.
            state_d = ST_RESP;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (tmo_expired) begin
          state_d = ST_RESP;
          rdata_d = TIMEOUT_RDATA;
          err_d   = 1'b1;
        end else if (HREADY) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // The first ERROR cycle has HREADY low and simply waits; the
        // completing cycle carries HRESP=ERROR with HREADY high.
        if (tmo_expired) begin
          state_d = ST_RESP;
          rdata_d = TIMEOUT_RDATA;
          err_d   = 1'b1;
        end else if (HREADY) begin
          state_d = ST_RESP;
          rdata_d = hwrite_q ? 32'h0 : HRDATA;
          err_d   = |(HRESP & HRESP_ERROR);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      haddr_q  <= 32'h0;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_BYTE;
      hwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // cmd_ready is masked by reset so nothing looks acceptable while the
  // reset is being applied.
  assign cmd_ready = (state_q == ST_IDLE) && HRESETn;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = haddr_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HWDATA    = hwdata_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign dbg_state = state_q;

endmodule
